// File: rtl/snn_pkg.sv
// Shared types and constants for the LIF engine: state encoding, LFSR constants,
// reset-mode codes and the saturating adder used on the membrane potentials.
package snn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENC_RD,
    S_ENC_CMP,
    S_INTEG,
    S_LEAK,
    S_DONE
  } snn_state_e;

  localparam logic [15:0] SNN_LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] SNN_SEED_DEFAULT = 16'hACE1;

  localparam logic SNN_RESET_ZERO = 1'b0;
  localparam logic SNN_RESET_SUB  = 1'b1;

  // Operands are sign-extended values of at most w (<32) bits, so the 32-bit sum is exact.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned w);
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sum = a + b;
    hi  = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo  = -(32'sd1 <<< (w - 1));
    if (sum > hi)      sat_add = hi;
    else if (sum < lo) sat_add = lo;
    else               sat_add = sum;
  endfunction

endpackage

// File: rtl/snn_lfsr.sv
// 16-bit Galois LFSR used for rate encoding; a zero seed is replaced by the default
// so the register can never lock up at all-zeros.
module snn_lfsr
  import snn_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             adv,
  input  logic [15:0]      seed,
  output logic [PIX_W-1:0] rand_val
);

  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SNN_SEED_DEFAULT;
    end else if (load) begin
      lfsr <= (seed == 16'd0) ? SNN_SEED_DEFAULT : seed;
    end else if (adv) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? SNN_LFSR_TAPS : 16'd0);
    end
  end

  assign rand_val = lfsr[PIX_W-1:0];

endmodule

// File: rtl/snn_lif_engine.sv
// Leaky-integrate-and-fire inference engine reading pixel/weight SRAMs over 1-cycle ports.
// Optional per-neuron refractory period is built when SNN_REFRACTORY_EN is defined.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_ENC_RD  | pixel read for input i
// S_ENC_CMP | rate-encode compare against LFSR
// S_INTEG   | weight reads + accumulate into vmem
// S_LEAK    | leak, threshold and fire, one neuron per cycle
// S_DONE    | one-cycle done pulse
module snn_lif_engine
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS  = 196,
  parameter int NUM_OUTPUTS = 10,
  parameter int PIX_W       = 8,
  parameter int W_W         = 8,
  parameter int VMEM_W      = 16,
  parameter int CNT_W       = 8,
  parameter int TS_W        = 10
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  output logic                                       busy,
  output logic                                       done,
  input  logic [TS_W-1:0]                            cfg_timesteps,
  input  logic signed [VMEM_W-1:0]                   cfg_vth,
  input  logic [3:0]                                 cfg_beta_shift,
  input  logic                                       cfg_reset_mode,
  input  logic [15:0]                                cfg_seed,
`ifdef SNN_REFRACTORY_EN
  input  logic [3:0]                                 cfg_refrac,
`endif
  output logic                                       pix_rd,
  output logic [$clog2(NUM_INPUTS)-1:0]              pix_addr,
  input  logic [PIX_W-1:0]                           pix_data,
  output logic                                       w_rd,
  output logic [$clog2(NUM_INPUTS*NUM_OUTPUTS)-1:0]  w_addr,
  input  logic signed [W_W-1:0]                      w_data,
  input  logic [$clog2(NUM_OUTPUTS)-1:0]             cnt_idx,
  output logic [CNT_W-1:0]                           cnt_o,
  output logic [TS_W-1:0]                            timestep_o
);

  localparam int PA_W = $clog2(NUM_INPUTS);
  localparam int WA_W = $clog2(NUM_INPUTS*NUM_OUTPUTS);
  localparam int CI_W = $clog2(NUM_OUTPUTS);
  localparam int K_W  = $clog2(NUM_OUTPUTS+1);

  snn_state_e                state;
  logic [PA_W-1:0]           i;
  logic [K_W-1:0]            k;
  logic [TS_W-1:0]           timestep;
  logic [TS_W-1:0]           ts_q;
  logic signed [VMEM_W-1:0]  vth_q;
  logic [3:0]                shift_q;
  logic                      mode_q;
  logic signed [VMEM_W-1:0]  vmem  [NUM_OUTPUTS];
  logic [CNT_W-1:0]          count [NUM_OUTPUTS];

  logic [PIX_W-1:0]          rand_val;
  logic                      spike, last_i, fire, integ_en, fire_en;
  logic [CI_W-1:0]           integ_idx, leak_idx;
  logic signed [VMEM_W-1:0]  v_leak, v_fire, v_integ;

  snn_lfsr #(.PIX_W(PIX_W)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     ((state == S_IDLE) && start),
    .adv      (state == S_ENC_CMP),
    .seed     (cfg_seed),
    .rand_val (rand_val)
  );

  assign spike     = (pix_data > rand_val) || (pix_data == '1);
  assign last_i    = (i == PA_W'(NUM_INPUTS-1));
  assign integ_idx = CI_W'(k - 1'b1);
  assign leak_idx  = CI_W'(k);
  assign v_integ   = VMEM_W'(sat_add(32'(vmem[integ_idx]), 32'(w_data), VMEM_W));

`ifdef SNN_REFRACTORY_EN
  logic [3:0] refrac_q;
  logic [3:0] refrac_cnt [NUM_OUTPUTS];
  assign integ_en = (refrac_cnt[integ_idx] == 4'd0);
  assign fire_en  = (refrac_cnt[leak_idx] == 4'd0);
`else
  assign integ_en = 1'b1;
  assign fire_en  = 1'b1;
`endif

  // A shift of zero disables leak rather than wiping the membrane.
  always_comb begin
    v_leak = vmem[leak_idx];
    if (shift_q != 4'd0)
      v_leak = VMEM_W'(sat_add(32'(vmem[leak_idx]), -(32'(vmem[leak_idx] >>> shift_q)), VMEM_W));
    fire   = (v_leak >= vth_q) && fire_en;
    v_fire = (mode_q == SNN_RESET_SUB) ? VMEM_W'(sat_add(32'(v_leak), -(32'(vth_q)), VMEM_W)) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pix_rd   <= 1'b0;
      pix_addr <= '0;
      w_rd     <= 1'b0;
      w_addr   <= '0;
      i        <= '0;
      k        <= '0;
      timestep <= '0;
      ts_q     <= '0;
      vth_q    <= '0;
      shift_q  <= '0;
      mode_q   <= SNN_RESET_ZERO;
      for (int n = 0; n < NUM_OUTPUTS; n++) begin
        vmem[n]  <= '0;
        count[n] <= '0;
      end
`ifdef SNN_REFRACTORY_EN
      refrac_q <= '0;
      for (int n = 0; n < NUM_OUTPUTS; n++) refrac_cnt[n] <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          ts_q     <= cfg_timesteps;
          vth_q    <= cfg_vth;
          shift_q  <= cfg_beta_shift;
          mode_q   <= cfg_reset_mode;
          timestep <= '0;
          i        <= '0;
          for (int n = 0; n < NUM_OUTPUTS; n++) begin
            vmem[n]  <= '0;
            count[n] <= '0;
          end
`ifdef SNN_REFRACTORY_EN
          refrac_q <= cfg_refrac;
          for (int n = 0; n < NUM_OUTPUTS; n++) refrac_cnt[n] <= '0;
`endif
          if (cfg_timesteps == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state    <= S_ENC_RD;
            busy     <= 1'b1;
            pix_rd   <= 1'b1;
            pix_addr <= '0;
          end
        end
        S_ENC_RD: begin
          pix_rd <= 1'b0;
          state  <= S_ENC_CMP;
        end
        S_ENC_CMP: begin
          if (spike) begin
            state  <= S_INTEG;
            k      <= '0;
            w_rd   <= 1'b1;
            w_addr <= WA_W'(i) * WA_W'(NUM_OUTPUTS);
          end else if (last_i) begin
            state <= S_LEAK;
            k     <= '0;
          end else begin
            i        <= i + 1'b1;
            state    <= S_ENC_RD;
            pix_rd   <= 1'b1;
            pix_addr <= i + 1'b1;
          end
        end
        S_INTEG: begin
          if (k != '0 && integ_en) vmem[integ_idx] <= v_integ;
          if (k == K_W'(NUM_OUTPUTS)) begin
            if (last_i) begin
              state <= S_LEAK;
              k     <= '0;
            end else begin
              i        <= i + 1'b1;
              state    <= S_ENC_RD;
              pix_rd   <= 1'b1;
              pix_addr <= i + 1'b1;
            end
          end else begin
            k <= k + 1'b1;
            if (k == K_W'(NUM_OUTPUTS-1)) w_rd <= 1'b0;
            else                          w_addr <= w_addr + 1'b1;
          end
        end
        S_LEAK: begin
          if (fire) begin
            vmem[leak_idx] <= v_fire;
            if (count[leak_idx] != '1) count[leak_idx] <= count[leak_idx] + 1'b1;
          end else begin
            vmem[leak_idx] <= v_leak;
          end
`ifdef SNN_REFRACTORY_EN
          if (refrac_cnt[leak_idx] != 4'd0) refrac_cnt[leak_idx] <= refrac_cnt[leak_idx] - 4'd1;
          else if (fire)                    refrac_cnt[leak_idx] <= refrac_q;
`endif
          if (k == K_W'(NUM_OUTPUTS-1)) begin
            timestep <= timestep + 1'b1;
            if (timestep + 1'b1 == ts_q) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              i        <= '0;
              state    <= S_ENC_RD;
              pix_rd   <= 1'b1;
              pix_addr <= '0;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cnt_o      = (32'(cnt_idx) < NUM_OUTPUTS) ? count[cnt_idx] : '0;
  assign timestep_o = timestep;

endmodule
